bsram_fifo_ctrl: RTL and testbench
==================================

# bsram_fifo_ctrl

Synchronous FIFO controller that drives the two ports of the dual-port block RAM (`bsram_test`-style, registered outputs, per-port `wr`/`ce`). Port A is used only for writes and port B only for reads. The controller adds valid/ready handshakes upstream and downstream. The RAM's port-B output register acts as the FIFO's one-entry output stage, so `out_data` is wired straight from `ram_doutb`.

## Interface
- `A_SIZE`, default 4: RAM address width. `DEPTH = 2**A_SIZE`. The attached RAM must be instantiated with this DEPTH.
- `W_SIZE`, default 8: data width.

- `clk`  in  1  clock
- `reset`  in  1  asynchronous, active-high
- `flush`  in  1  synchronous clear of all FIFO state
- `in_valid`  in  1  upstream word present
- `in_ready`  out  1  controller can accept a word
- `in_data`  in  W_SIZE  upstream word
- `out_valid`  out  1  `out_data` holds a valid word
- `out_ready`  in  1  downstream accepts the word
- `out_data`  out  W_SIZE  equals `ram_doutb`
- `level`  out  A_SIZE+1  total words held, 0..DEPTH+1
- `ram_addra`  out  A_SIZE  write pointer
- `ram_dina`  out  W_SIZE  equals `in_data`
- `ram_wra`, `ram_cea`  out  1  both equal `push`
- `ram_addrb`  out  A_SIZE  read pointer
- `ram_wrb`  out  1  constant 0
- `ram_ceb`  out  1  equals `rd_issue`
- `ram_doutb`  in  W_SIZE  RAM port-B registered output
- `max_level`  out  A_SIZE+1  only present with `BSRAM_FIFO_STATS_EN`

## Operation
- State registers:
  - `wr_ptr`, `rd_ptr`: A_SIZE bits each; they wrap modulo DEPTH naturally.
  - `ram_count`: A_SIZE+1 bits, 0..DEPTH; counts words in RAM that have not been read yet.
  - `out_valid`: flag for the output stage.
- Combinational signals:
  - `in_ready = (ram_count != DEPTH) && !flush`.
  - `push = in_valid && in_ready`.
  - `pop = out_valid && out_ready`.
  - `rd_issue = (ram_count != 0) && (!out_valid || out_ready) && !flush`.
- On `push`: the RAM writes `in_data` at `wr_ptr`. `wr_ptr` increments.
- On `rd_issue`: the RAM reads `rd_ptr`. `rd_ptr` increments. `out_valid` is set next cycle.
- `ram_count` update:
  - `+1` on push only.
  - `-1` on rd_issue only.
  - Unchanged when both occur in the same cycle.
- `out_valid` next-state, in priority order:
  - 1 if `rd_issue`.
  - Otherwise 0 if `pop`.
  - Otherwise hold.
- `level = ram_count + out_valid`. Total capacity is DEPTH+1 words.
- Port A and port B never access the same address in one cycle:
  - Pointers are equal only at `ram_count` 0, when no read is issued.
  - Pointers are equal only at `ram_count` DEPTH, when no write is issued.
- Flush:
  - `wr_ptr`, `rd_ptr`, `ram_count` and `out_valid` clear to 0 at the next edge.
  - No RAM access occurs in the flush cycle.
  - A stale `ram_doutb` is masked by `out_valid = 0`.
  - `in_data` presented during flush is dropped, since `in_ready` is 0.
- `out_data` must remain stable while `out_valid && !out_ready`. This holds because port B is only enabled on `rd_issue`.

## Timing
- Reset values:
  - Pointers 0, `ram_count` 0, `out_valid` 0, `level` 0, `max_level` 0.
  - `in_ready` 1 once `flush` is low.
  - `out_data` 0, because the RAM also clears `doutb`.
- Reset asserted mid-operation discards all contents immediately (asynchronous). RAM array contents are don't-care.
- Write-to-read latency into an empty FIFO:
  - Push accepted at edge t.
  - `rd_issue` is high in the cycle after t.
  - `out_valid` is high after edge t+1.
  - Total: 2 cycles.
- Sustained throughput is 1 word/cycle in and out when `out_ready` is held high.
- Full boundary: at `ram_count == DEPTH`, `in_ready` is 0 even if a read issues that cycle. There is no combinational bypass from `out_ready` to `in_ready`.
- Empty boundary: a push to an empty FIFO is never read in the same cycle.

## Configuration
- `BSRAM_FIFO_STATS_EN` defined:
  - Adds the `max_level` register and port.
  - `max_level` tracks the maximum `level` seen since reset or the last flush.
  - It updates one cycle after `level`.
  - It is cleared by `reset` and `flush`.
- Undefined: the port and its register do not exist. All other behaviour is identical.

## Test plan
(All scenarios use A_SIZE=2, W_SIZE=8, so DEPTH=4 and capacity is 5.)
- Reset, then push 0xA5 with `out_ready` 0:
  - `out_valid` rises 2 cycles after the push edge with `out_data` 0xA5.
  - `level` 1, and 0xA5 holds stable for 10 idle cycles.
- Push 0x01..0x06 back-to-back with `out_ready` 0:
  - Five words are accepted, then `in_ready` is 0 and `level` is 5.
  - 0x06 is not accepted until a pop.
- Then raise `out_ready`: outputs are 0x01..0x05 in order, one per cycle after the first, and pointer wrap is exercised.
- Streaming with `in_valid`/`out_ready` high for 20 words 0x10..0x23: all 20 arrive in order with no gaps after the 2-cycle fill.
- Fill to 3 words, then assert `flush` for one cycle together with `in_valid` and data 0x77:
  - Next cycle `level` 0, `out_valid` 0.
  - 0x77 is not stored.
  - A subsequent push 0x88 emerges first.
- Assert `reset` asynchronously while 4 words are held and `out_valid` is 1: `out_valid`, `level` and `out_data` go to 0 without a clock edge.
- With `BSRAM_FIFO_STATS_EN`: fill to 5, drain to 0: `max_level` reads 5 and returns to 0 after `flush`.

Source files
------------

// File: rtl/bsram_fifo_ctrl_if.sv
// bsram_fifo_ctrl_if: stream handshakes, RAM port wiring and status of the BSRAM FIFO controller.
// max_level exists only when BSRAM_FIFO_STATS_EN is defined.
interface bsram_fifo_ctrl_if #(
  parameter int A_SIZE = 4,
  parameter int W_SIZE = 8
);
  logic flush, in_valid, in_ready, out_valid, out_ready;
  logic [W_SIZE-1:0] in_data, out_data, ram_dina, ram_doutb;
  logic [A_SIZE:0] level;
  logic [A_SIZE-1:0] ram_addra, ram_addrb;
  logic ram_wra, ram_cea, ram_wrb, ram_ceb;
`ifdef BSRAM_FIFO_STATS_EN
  logic [A_SIZE:0] max_level;
`endif
  modport slave (
    input flush, in_valid, in_data, out_ready, ram_doutb,
    output in_ready, out_valid, out_data, level,
    output ram_addra, ram_dina, ram_wra, ram_cea, ram_addrb, ram_wrb, ram_ceb
`ifdef BSRAM_FIFO_STATS_EN
    , output max_level
`endif
  );
  modport master (
    output flush, in_valid, in_data, out_ready, ram_doutb,
    input in_ready, out_valid, out_data, level,
    input ram_addra, ram_dina, ram_wra, ram_cea, ram_addrb, ram_wrb, ram_ceb
`ifdef BSRAM_FIFO_STATS_EN
    , input max_level
`endif
  );
endinterface

// File: rtl/bsram_fifo_ctrl.sv
// bsram_fifo_ctrl: FIFO controller over a dual-port BSRAM (port A writes, port B reads into its output register).
// Define BSRAM_FIFO_STATS_EN to add the max_level high-water register.
module bsram_fifo_ctrl #(
  parameter int A_SIZE = 4,
  parameter int W_SIZE = 8
) (
  input logic clk,
  input logic reset,
  bsram_fifo_ctrl_if.slave bus
);
  localparam logic [A_SIZE:0] FULL = (A_SIZE+1)'(2**A_SIZE);
  logic [A_SIZE-1:0] wr_ptr, rd_ptr;
  logic [A_SIZE:0] ram_count, level;
  logic out_valid, in_ready, push, pop, rd_issue;
  assign in_ready = (ram_count != FULL) && !bus.flush;
  assign push = bus.in_valid && in_ready;
  assign pop = out_valid && bus.out_ready;
  // port B's output register is the output stage, so only read when it is free or being emptied
  assign rd_issue = (ram_count != '0) && (!out_valid || bus.out_ready) && !bus.flush;
  assign level = ram_count + (A_SIZE+1)'(out_valid);
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      ram_count <= '0;
      out_valid <= 1'b0;
    end else if (bus.flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      ram_count <= '0;
      out_valid <= 1'b0;
    end else begin
      wr_ptr <= push ? wr_ptr + A_SIZE'(1) : wr_ptr;
      rd_ptr <= rd_issue ? rd_ptr + A_SIZE'(1) : rd_ptr;
      ram_count <= (push && !rd_issue) ? ram_count + (A_SIZE+1)'(1) :
                   (rd_issue && !push) ? ram_count - (A_SIZE+1)'(1) : ram_count;
      out_valid <= rd_issue ? 1'b1 : pop ? 1'b0 : out_valid;
    end
`ifdef BSRAM_FIFO_STATS_EN
  logic [A_SIZE:0] max_level;
  always_ff @(posedge clk or posedge reset)
    if (reset) max_level <= '0;
    else if (bus.flush) max_level <= '0;
    else if (level > max_level) max_level <= level;
  assign bus.max_level = max_level;
`endif
  assign bus.in_ready = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_data = bus.ram_doutb;
  assign bus.level = level;
  assign bus.ram_addra = wr_ptr;
  assign bus.ram_dina = bus.in_data;
  assign bus.ram_wra = push;
  assign bus.ram_cea = push;
  assign bus.ram_addrb = rd_ptr;
  assign bus.ram_wrb = 1'b0;
  assign bus.ram_ceb = rd_issue;
endmodule

// File: tb/tb_bsram_fifo_ctrl.sv
// tb_bsram_fifo_ctrl: directed and random stimulus against a queue-based model, with a registered-output RAM attached.
module tb_bsram_fifo_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int n_chk = 0;
  int n_err = 0;
  bit acc;
  logic [7:0] mq[$];
  bit m_ov;
  logic [7:0] m_od;
  int m_max;
  logic [7:0] mem [4];
  bsram_fifo_ctrl_if #(.A_SIZE(2), .W_SIZE(8)) bus ();
  bsram_fifo_ctrl #(.A_SIZE(2), .W_SIZE(8)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk or posedge reset)
    if (reset) bus.ram_doutb <= '0;
    else begin
      if (bus.ram_cea && bus.ram_wra) mem[bus.ram_addra] <= bus.ram_dina;
      if (bus.ram_ceb && !bus.ram_wrb) bus.ram_doutb <= mem[bus.ram_addrb];
    end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic model_clear();
    mq.delete();
    m_ov = 0;
    m_od = '0;
    m_max = 0;
  endtask
  task automatic cycle(input bit fl, input bit iv, input logic [7:0] d, input bit ordy, output bit accepted);
    bit ir, ri, pop;
    int lvl;
    @(negedge clk);
    bus.flush = fl;
    bus.in_valid = iv;
    bus.in_data = d;
    bus.out_ready = ordy;
    #1;
    ir = (mq.size() != 4) && !fl;
    lvl = mq.size() + int'(m_ov);
    check("in_ready", 32'(bus.in_ready), 32'(ir));
    check("out_valid", 32'(bus.out_valid), 32'(m_ov));
    check("level", 32'(bus.level), 32'(lvl));
    check("out_data", 32'(bus.out_data), 32'(m_od));
    check("ram_wrb", 32'(bus.ram_wrb), 32'd0);
    if (bus.ram_cea && bus.ram_ceb) check("addr_clash", 32'(bus.ram_addra == bus.ram_addrb), 32'd0);
`ifdef BSRAM_FIFO_STATS_EN
    check("max_level", 32'(bus.max_level), 32'(m_max));
`endif
    accepted = iv && ir;
    ri = (mq.size() != 0) && (!m_ov || ordy) && !fl;
    pop = m_ov && ordy;
    if (fl) begin
      mq.delete();
      m_ov = 0;
      m_max = 0;
    end else begin
      if (lvl > m_max) m_max = lvl;
      if (ri) begin
        m_od = mq.pop_front();
        m_ov = 1;
      end else if (pop) m_ov = 0;
      if (accepted) mq.push_back(d);
    end
  endtask
  initial begin
    int nxt, p;
    bus.flush = 0;
    bus.in_valid = 0;
    bus.in_data = '0;
    bus.out_ready = 0;
    model_clear();
    repeat (2) @(negedge clk);
    reset = 0;
    cycle(0, 1, 8'hA5, 0, acc);
    repeat (12) cycle(0, 0, 8'h00, 0, acc);
    repeat (3) cycle(0, 0, 8'h00, 1, acc);
    nxt = 1;
    for (int i = 0; i < 30; i++) begin
      cycle(0, nxt <= 6, 8'(nxt), i >= 10, acc);
      if (acc) nxt++;
    end
    nxt = 16;
    for (int i = 0; i < 40; i++) begin
      cycle(0, nxt <= 35, 8'(nxt), 1, acc);
      if (acc) nxt++;
    end
    for (int i = 0; i < 5; i++) cycle(0, i < 3, 8'(8'h30 + i), 0, acc);
    cycle(1, 1, 8'h77, 0, acc);
    cycle(0, 1, 8'h88, 0, acc);
    repeat (6) cycle(0, 0, 8'h00, 1, acc);
    for (int i = 0; i < 6; i++) cycle(0, i < 4, 8'(8'hC0 + i), 0, acc);
    #1;
    reset = 1;
    #1;
    check("async_out_valid", 32'(bus.out_valid), 32'd0);
    check("async_level", 32'(bus.level), 32'd0);
    check("async_out_data", 32'(bus.out_data), 32'd0);
    model_clear();
    @(negedge clk);
    reset = 0;
    for (int i = 0; i < 3000; i++) begin
      p = (i / 150) % 3 == 0 ? 10 : (i / 150) % 3 == 1 ? 50 : 90;
      cycle($urandom_range(0, 63) == 0, $urandom_range(0, 3) != 0, 8'($urandom),
            $urandom_range(0, 99) < p, acc);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule
